// File: rtl/dma_priority_arbiter.sv
// Priority/acknowledge block of a 4-channel 8237-style DMA controller.
// Arbitrates hardware and software requests, raises hrq and drives dack for the granted channel.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request pending, hrq low; winner latched when any eff bit is set
// ST_REQ   | hrq high, waiting for assertDACK; falls back if the request drops
// ST_SERVE | dack held for activeCh until deassertDACK ends the service
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic [NUM_CH-1:0] dreq,
  input  logic              dreqActiveLow,
  input  logic              dackActiveHigh,
  input  logic              rotatingPriority,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swRequest,
  input  logic              assertDACK,
  input  logic              deassertDACK,
  output logic              hrq,
  output logic [NUM_CH-1:0] dack,
  output logic [CH_W-1:0]   activeCh,
  output logic              chActive,
  output logic [NUM_CH-1:0] swReqClr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   dack_int_q, dack_int_d;
  logic [CH_W-1:0]     active_ch_q, active_ch_d;
  logic                ch_active_q, ch_active_d;
  logic [NUM_CH-1:0]   sw_req_clr_q, sw_req_clr_d;
  logic [CH_W-1:0]     top_q, top_d;

  logic [NUM_CH-1:0]   eff;
  logic [CH_W-1:0]     winner;
  logic [CH_W-1:0]     scan_idx;
  logic                found;

  // Software requests bypass the mask.
  assign eff = ((dreq ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | swRequest;

  // Fixed mode scans from ch0; rotating mode scans from top_q with wrap-around.
  always_comb begin
    winner   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = rotatingPriority ? CH_W'((int'(top_q) + k) % NUM_CH) : CH_W'(k);
      if (!found && eff[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      hrq_q        <= 1'b0;
      dack_int_q   <= '0;
      active_ch_q  <= '0;
      ch_active_q  <= 1'b0;
      sw_req_clr_q <= '0;
      top_q        <= '0;
    end else begin
      state_q      <= state_d;
      hrq_q        <= hrq_d;
      dack_int_q   <= dack_int_d;
      active_ch_q  <= active_ch_d;
      ch_active_q  <= ch_active_d;
      sw_req_clr_q <= sw_req_clr_d;
      top_q        <= top_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (|eff) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (assertDACK)             state_d = ST_SERVE;
        else if (!eff[active_ch_q]) state_d = ST_IDLE;
      end
      ST_SERVE: begin
        if (deassertDACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hrq_d        = hrq_q;
    dack_int_d   = dack_int_q;
    active_ch_d  = active_ch_q;
    ch_active_d  = ch_active_q;
    sw_req_clr_d = '0;
    top_d        = top_q;
    case (state_q)
      ST_IDLE: begin
        if (|eff) begin
          active_ch_d = winner;
          hrq_d       = 1'b1;
        end
      end
      ST_REQ: begin
        if (assertDACK) begin
          dack_int_d              = '0;
          dack_int_d[active_ch_q] = 1'b1;
          ch_active_d             = 1'b1;
        end else if (!eff[active_ch_q]) begin
          hrq_d = 1'b0;
        end
      end
      ST_SERVE: begin
        if (deassertDACK) begin
          hrq_d                     = 1'b0;
          dack_int_d                = '0;
          ch_active_d               = 1'b0;
          sw_req_clr_d[active_ch_q] = swRequest[active_ch_q];
          // Served channel drops to lowest priority.
          if (rotatingPriority) top_d = CH_W'((int'(active_ch_q) + 1) % NUM_CH);
        end
      end
      default: begin
        hrq_d       = 1'b0;
        dack_int_d  = '0;
        ch_active_d = 1'b0;
      end
    endcase
  end

  assign hrq      = hrq_q;
  assign dack     = dackActiveHigh ? dack_int_q : ~dack_int_q;
  assign activeCh = active_ch_q;
  assign chActive = ch_active_q;
  assign swReqClr = sw_req_clr_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Scoreboard bench for dma_priority_arbiter: directed scenarios plus randomized
// request/mask/polarity traffic checked against a transaction-level model.
module tb_dma_priority_arbiter;

  logic       clk;
  logic       resetN;
  logic [3:0] dreq;
  logic       dreqActiveLow;
  logic       dackActiveHigh;
  logic       rotatingPriority;
  logic [3:0] maskReg;
  logic [3:0] swRequest;
  logic       assertDACK;
  logic       deassertDACK;
  logic       hrq;
  logic [3:0] dack;
  logic [1:0] activeCh;
  logic       chActive;
  logic [3:0] swReqClr;

  typedef struct {
    int         ch;
    logic [3:0] dack_exp;
  } grant_t;

  grant_t     grant_q[$];
  logic [3:0] swclr_q[$];
  int         model_top;
  int         checks;
  int         errors;
  logic       prev_act;

  dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .dreq             (dreq),
    .dreqActiveLow    (dreqActiveLow),
    .dackActiveHigh   (dackActiveHigh),
    .rotatingPriority (rotatingPriority),
    .maskReg          (maskReg),
    .swRequest        (swRequest),
    .assertDACK       (assertDACK),
    .deassertDACK     (deassertDACK),
    .hrq              (hrq),
    .dack             (dack),
    .activeCh         (activeCh),
    .chActive         (chActive),
    .swReqClr         (swReqClr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Highest-priority requester: fixed = lowest index, rotating = first set bit from top.
  function automatic int model_winner(input logic [3:0] e, input bit rot, input int top);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = rot ? (top + k) % 4 : k;
      if (e[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant or a clear pulse.
  initial prev_act = 1'b0;
  always @(negedge clk) begin
    logic [3:0] act_bits;
    if (chActive && !prev_act) begin
      if (grant_q.size() == 0) begin
        chk("grant_unexpected", 32'(activeCh), 32'hFFFF_FFFF);
      end else begin
        grant_t g;
        g = grant_q.pop_front();
        chk("grant_ch", 32'(activeCh), 32'(g.ch));
        chk("grant_dack", 32'(dack), 32'(g.dack_exp));
      end
    end
    if (swReqClr != 4'h0) begin
      if (swclr_q.size() == 0) chk("swclr_unexpected", 32'(swReqClr), 32'h0);
      else chk("swclr", 32'(swReqClr), 32'(swclr_q.pop_front()));
    end
    act_bits = dackActiveHigh ? dack : ~dack;
    chk("dack_onehot_in_serve", 32'(($countones(act_bits) <= 1) && (chActive || act_bits == 4'h0)), 32'h1);
    prev_act = chActive;
  end

  // One full request/grant/service transaction starting from IDLE.
  task automatic serve(input logic [3:0] d, input logic [3:0] m, input logic [3:0] s,
                       input bit dl, input bit dh, input bit rt, input bit both, input int dly);
    logic [3:0] eff, inact, onehot;
    int w, n;
    dreq = d; maskReg = m; swRequest = s;
    dreqActiveLow = dl; dackActiveHigh = dh; rotatingPriority = rt;
    eff   = ((d ^ {4{dl}}) & ~m) | s;
    inact = dh ? 4'h0 : 4'hF;
    if (eff == 4'h0) begin
      repeat (2) begin
        tick();
        chk("idle_no_hrq", 32'(hrq), 32'h0);
      end
      return;
    end
    w = model_winner(eff, rt, model_top);
    onehot = 4'h0;
    onehot[w] = 1'b1;
    grant_q.push_back('{ch: w, dack_exp: (dh ? onehot : ~onehot)});
    tick();
    chk("hrq_rise", 32'(hrq), 32'h1);
    chk("req_activeCh", 32'(activeCh), 32'(w));
    chk("req_dack_inactive", 32'(dack), 32'(inact));
    repeat (dly) begin
      tick();
      chk("hrq_hold_req", 32'(hrq), 32'h1);
    end
    assertDACK = 1'b1; deassertDACK = both;
    tick();
    assertDACK = 1'b0; deassertDACK = 1'b0;
    chk("hrq_serve", 32'(hrq), 32'h1);
    n = $urandom_range(0, 2);
    repeat (n) begin
      dreq = 4'($urandom); maskReg = 4'($urandom);
      tick();
      chk("serve_hold", 32'({hrq, chActive, activeCh}), 32'({2'b11, 2'(w)}));
    end
    deassertDACK = 1'b1; assertDACK = 1'($urandom);
    if (s[w]) swclr_q.push_back(onehot);
    if (rt) model_top = (w + 1) % 4;
    tick();
    deassertDACK = 1'b0; assertDACK = 1'b0;
    dreq = {4{dl}}; maskReg = 4'h0; swRequest = 4'h0;
    chk("hrq_drop", 32'(hrq), 32'h0);
    chk("chActive_drop", 32'(chActive), 32'h0);
    chk("dack_drop", 32'(dack), 32'(inact));
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    tick();
    dreq = 4'h0; maskReg = 4'h0; swRequest = 4'h0;
    dreqActiveLow = 1'b0; dackActiveHigh = 1'b1; rotatingPriority = 1'b0;
    resetN = 1'b1;
    model_top = 0;
  endtask

  initial begin
    checks = 0; errors = 0; model_top = 0;
    resetN = 1'b0; dreq = 4'hF; maskReg = 4'h0; swRequest = 4'h0;
    dreqActiveLow = 1'b0; dackActiveHigh = 1'b1; rotatingPriority = 1'b0;
    assertDACK = 1'b0; deassertDACK = 1'b0;

    repeat (3) tick();
    chk("rst_hrq", 32'(hrq), 32'h0);
    chk("rst_dack", 32'(dack), 32'h0);
    chk("rst_activeCh", 32'(activeCh), 32'h0);
    chk("rst_chActive", 32'(chActive), 32'h0);
    chk("rst_swReqClr", 32'(swReqClr), 32'h0);
    dreq = 4'h0; resetN = 1'b1;
    tick();

    // Fixed priority: ch1 of 1010, then ch3.
    serve(4'b1010, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    serve(4'b1000, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Rotating: 0,1,2,3,0 with all channels requesting.
    do_reset();
    for (int i = 0; i < 5; i++) serve(4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // Mask blocks hardware request; software request bypasses mask and gets cleared.
    do_reset();
    serve(4'b0100, 4'b0100, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    serve(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Request dropped while in REQ returns to IDLE without a grant.
    dreq = 4'b0100;
    tick();
    chk("drop_hrq_req", 32'(hrq), 32'h1);
    chk("drop_activeCh", 32'(activeCh), 32'h2);
    dreq = 4'h0;
    tick();
    chk("drop_hrq_idle", 32'(hrq), 32'h0);
    tick();
    chk("drop_stay_idle", 32'({hrq, chActive}), 32'h0);

    // Inverted polarities with both strobes together in REQ.
    serve(4'b1110, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    dreqActiveLow = 1'b0; dackActiveHigh = 1'b1; dreq = 4'h0;

    // Reset mid-service clears everything including the rotation pointer.
    serve(4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    dreq = 4'b0100; rotatingPriority = 1'b1;
    grant_q.push_back('{ch: 2, dack_exp: 4'b0100});
    tick();
    assertDACK = 1'b1;
    tick();
    assertDACK = 1'b0;
    chk("mid_in_serve", 32'(chActive), 32'h1);
    resetN = 1'b0;
    tick();
    chk("mid_rst_hrq", 32'(hrq), 32'h0);
    chk("mid_rst_dack", 32'(dack), 32'h0);
    chk("mid_rst_chActive", 32'(chActive), 32'h0);
    chk("mid_rst_activeCh", 32'(activeCh), 32'h0);
    dreq = 4'h0; resetN = 1'b1; model_top = 0;
    tick();
    serve(4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      serve(4'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (3) tick();
    chk("grant_queue_empty", 32'(grant_q.size()), 32'h0);
    chk("swclr_queue_empty", 32'(swclr_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
